// File: rtl/wb_trace_buffer.sv
// Writeback trace buffer: timestamps register-file writeback events behind an
// arm/trigger FSM and queues them in a first-word-fall-through FIFO for a consumer.
module wb_trace_buffer #(
    parameter int DEPTH        = 16,
    parameter int DATA_W       = 32,
    parameter int REG_W        = 4,
    parameter int CYC_W        = 16,
    parameter bit STOP_ON_FULL = 1'b0
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   arm,
    input  logic                   trig_en,
    input  logic [DATA_W-1:0]      trig_pc,
    input  logic                   wb_valid,
    input  logic [REG_W-1:0]       wb_reg,
    input  logic [DATA_W-1:0]      wb_data,
    input  logic [DATA_W-1:0]      wb_pc,
    input  logic                   rd_ready,
    output logic                   rd_valid,
    output logic [REG_W-1:0]       rd_reg,
    output logic [DATA_W-1:0]      rd_data,
    output logic [DATA_W-1:0]      rd_pc,
    output logic [CYC_W-1:0]       rd_cycle,
    output logic [$clog2(DEPTH):0] level,
    output logic                   overflow,
    output logic [7:0]             drop_cnt,
    output logic [1:0]             state
);
    localparam int AW    = $clog2(DEPTH);
    localparam int CNT_W = AW + 1;

    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        ARMED   = 2'b01,
        CAPTURE = 2'b10,
        HALT    = 2'b11
    } state_t;

    typedef struct packed {
        logic [CYC_W-1:0]  cycle;
        logic [REG_W-1:0]  reg_idx;
        logic [DATA_W-1:0] data;
        logic [DATA_W-1:0] pc;
    } entry_t;

    state_t           fsm;
    entry_t           mem [DEPTH];
    entry_t           new_entry;
    entry_t           head_nxt;
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW-1:0]    rd_ptr_nxt;
    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] count_nxt;
    logic [CYC_W-1:0] cyc;
    logic             empty;
    logic             full;
    logic             pop;
    logic             trig_hit;
    logic             push_req;
    logic             drop;
    logic             push;

    // NOTE: every signal gets a default at the top of always_comb so no path can infer a latch.
    always_comb begin
        empty      = (count == '0);
        // count never exceeds DEPTH, so its top bit alone marks a full FIFO
        full       = count[AW];
        pop        = !empty && rd_ready;
        trig_hit   = arm && (fsm == ARMED) &&
                     (!trig_en || (wb_valid && (wb_pc == trig_pc)));
        push_req   = arm && wb_valid && ((fsm == CAPTURE) || trig_hit);
        drop       = push_req && full && !pop;
        push       = push_req && !drop;
        new_entry  = '{cycle: cyc, reg_idx: wb_reg, data: wb_data, pc: wb_pc};
        rd_ptr_nxt = pop ? rd_ptr + AW'(1) : rd_ptr;
        count_nxt  = count;
        case ({push, pop})
            2'b10:   count_nxt = count + CNT_W'(1);
            2'b01:   count_nxt = count - CNT_W'(1);
            default: count_nxt = count;
        endcase
        // The entry being written this edge becomes the head when it lands on the next read slot.
        if (push && (rd_ptr_nxt == wr_ptr)) head_nxt = new_entry;
        else                                head_nxt = mem[rd_ptr_nxt];
    end

    // NOTE: the storage array has no reset; pointers and count alone decide which slots are live.
    always_ff @(posedge clock) begin
        if (push && !reset) mem[wr_ptr] <= new_entry;
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clock) begin
        if (reset) begin
            fsm      <= IDLE;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            cyc      <= '0;
            rd_valid <= 1'b0;
            rd_reg   <= '0;
            rd_data  <= '0;
            rd_pc    <= '0;
            rd_cycle <= '0;
            overflow <= 1'b0;
            drop_cnt <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            rd_ptr   <= rd_ptr_nxt;
            count    <= count_nxt;
            rd_valid <= (count_nxt != '0);
            if ((count_nxt != '0) && (pop || empty)) begin
                rd_reg   <= head_nxt.reg_idx;
                rd_data  <= head_nxt.data;
                rd_pc    <= head_nxt.pc;
                rd_cycle <= head_nxt.cycle;
            end

            if (fsm == IDLE) begin
                if (arm) begin
                    cyc      <= '0;
                    overflow <= 1'b0;
                    drop_cnt <= '0;
                end
            end else begin
                cyc <= cyc + CYC_W'(1);
                if (drop) begin
                    overflow <= 1'b1;
                    if (drop_cnt != 8'hFF) drop_cnt <= drop_cnt + 8'd1;
                end
            end

            if (!arm) begin
                fsm <= IDLE;
            end else begin
                case (fsm)
                    IDLE:    fsm <= ARMED;
                    ARMED:   if (trig_hit) fsm <= CAPTURE;
                    CAPTURE: if (STOP_ON_FULL && drop) fsm <= HALT;
                    HALT:    fsm <= HALT;
                endcase
            end
        end
    end

    assign level = count;
    assign state = fsm;

endmodule

// File: tb/tb_wb_trace_buffer.sv
// Bench for wb_trace_buffer: a drop-on-full and a halt-on-full instance share stimulus and are
// compared every cycle against a queue-based reference model, plus directed scenario checks.
module tb_wb_trace_buffer;
    localparam int DEPTH = 16;
    localparam int S_IDLE = 0, S_ARMED = 1, S_CAP = 2, S_HALT = 3;

    typedef struct packed {
        logic [15:0] cyc;
        logic [3:0]  r;
        logic [31:0] d;
        logic [31:0] pc;
    } ent_t;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        arm = 1'b0, trig_en = 1'b0, wb_valid = 1'b0, rd_ready = 1'b0;
    logic [31:0] trig_pc = '0, wb_data = '0, wb_pc = '0;
    logic [3:0]  wb_reg = '0;

    logic        rdv  [2];
    logic [3:0]  rreg [2];
    logic [31:0] rdat [2];
    logic [31:0] rpc  [2];
    logic [15:0] rcyc [2];
    logic [4:0]  lvl  [2];
    logic        ovf  [2];
    logic [7:0]  dcnt [2];
    logic [1:0]  st   [2];

    int   m_st   [2];
    logic [15:0] m_cyc [2];
    bit   m_ovf  [2];
    int   m_drop [2];
    ent_t mq     [2][$];
    ent_t m_head [2];

    int n_checks = 0;
    int n_err    = 0;

    always #5 clock = ~clock;

    wb_trace_buffer #(.DEPTH(DEPTH), .STOP_ON_FULL(1'b0)) dut (
        .clock(clock), .reset(reset), .arm(arm), .trig_en(trig_en), .trig_pc(trig_pc),
        .wb_valid(wb_valid), .wb_reg(wb_reg), .wb_data(wb_data), .wb_pc(wb_pc),
        .rd_ready(rd_ready), .rd_valid(rdv[0]), .rd_reg(rreg[0]), .rd_data(rdat[0]),
        .rd_pc(rpc[0]), .rd_cycle(rcyc[0]), .level(lvl[0]), .overflow(ovf[0]),
        .drop_cnt(dcnt[0]), .state(st[0])
    );

    wb_trace_buffer #(.DEPTH(DEPTH), .STOP_ON_FULL(1'b1)) dut_halt (
        .clock(clock), .reset(reset), .arm(arm), .trig_en(trig_en), .trig_pc(trig_pc),
        .wb_valid(wb_valid), .wb_reg(wb_reg), .wb_data(wb_data), .wb_pc(wb_pc),
        .rd_ready(rd_ready), .rd_valid(rdv[1]), .rd_reg(rreg[1]), .rd_data(rdat[1]),
        .rd_pc(rpc[1]), .rd_cycle(rcyc[1]), .level(lvl[1]), .overflow(ovf[1]),
        .drop_cnt(dcnt[1]), .state(st[1])
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference behaviour for one edge, from the inputs as they stand before the edge.
    task automatic model_edge(input int i);
        bit   full, pop, hit, want, dropped;
        ent_t e;
        if (reset) begin
            m_st[i] = S_IDLE;
            mq[i].delete();
            m_cyc[i] = '0;
            m_ovf[i] = 1'b0;
            m_drop[i] = 0;
            m_head[i] = '0;
            return;
        end
        full = (mq[i].size() == DEPTH);
        pop  = (mq[i].size() != 0) && rd_ready;
        hit  = arm && (m_st[i] == S_ARMED) && (!trig_en || (wb_valid && (wb_pc == trig_pc)));
        want = arm && wb_valid && ((m_st[i] == S_CAP) || hit);
        e = '{cyc: m_cyc[i], r: wb_reg, d: wb_data, pc: wb_pc};
        if (pop) void'(mq[i].pop_front());
        dropped = want && full && !pop;
        if (want && !dropped) mq[i].push_back(e);
        if (dropped) begin
            m_ovf[i] = 1'b1;
            if (m_drop[i] < 255) m_drop[i]++;
        end
        if (mq[i].size() != 0) m_head[i] = mq[i][0];

        if (m_st[i] == S_IDLE) begin
            if (arm) begin
                m_cyc[i] = '0;
                m_ovf[i] = 1'b0;
                m_drop[i] = 0;
            end
        end else begin
            m_cyc[i] = m_cyc[i] + 16'd1;
        end

        if (!arm)                                    m_st[i] = S_IDLE;
        else if (m_st[i] == S_IDLE)                  m_st[i] = S_ARMED;
        else if (m_st[i] == S_ARMED && hit)          m_st[i] = S_CAP;
        else if (m_st[i] == S_CAP && dropped && i == 1) m_st[i] = S_HALT;
    endtask

    task automatic compare_all();
        for (int i = 0; i < 2; i++) begin
            check($sformatf("i%0d rd_valid", i), rdv[i], mq[i].size() != 0);
            check($sformatf("i%0d level", i), lvl[i], mq[i].size());
            check($sformatf("i%0d state", i), st[i], m_st[i]);
            check($sformatf("i%0d overflow", i), ovf[i], m_ovf[i]);
            check($sformatf("i%0d drop_cnt", i), dcnt[i], m_drop[i]);
            check($sformatf("i%0d rd_reg", i), rreg[i], m_head[i].r);
            check($sformatf("i%0d rd_data", i), rdat[i], m_head[i].d);
            check($sformatf("i%0d rd_pc", i), rpc[i], m_head[i].pc);
            check($sformatf("i%0d rd_cycle", i), rcyc[i], m_head[i].cyc);
        end
    endtask

    // Called at a falling edge with inputs already set: one rising edge, model, then compare.
    task automatic step();
        @(posedge clock);
        model_edge(0);
        model_edge(1);
        @(negedge clock);
        compare_all();
    endtask

    task automatic event_in(input logic v, input logic [3:0] r, input logic [31:0] d,
                            input logic [31:0] pc);
        wb_valid = v;
        wb_reg   = r;
        wb_data  = d;
        wb_pc    = pc;
    endtask

    initial begin
        // Reset
        @(negedge clock);
        step();
        step();
        check("reset state", st[0], 2'b00);
        check("reset level", lvl[0], 5'd0);
        reset = 1'b0;

        // T1: immediate capture, three events drained in order
        arm = 1'b1; trig_en = 1'b0; rd_ready = 1'b1;
        event_in(1'b0, 4'd0, 32'd0, 32'd0);
        step();
        check("t1 armed", st[0], 2'b01);
        step();
        check("t1 capture", st[0], 2'b10);
        for (int k = 1; k <= 3; k++) begin
            event_in(1'b1, 4'(k), 32'h11 * k, 32'h200 + 32'(4 * k));
            step();
            check("t1 head reg", rreg[0], 4'(k));
            check("t1 head data", rdat[0], 32'h11 * k);
            check("t1 head stamp", rcyc[0], 16'(k));
        end
        event_in(1'b0, 4'd0, 32'd0, 32'd0);
        step();
        check("t1 drained", lvl[0], 5'd0);

        // T2: trigger on PC 0x100
        arm = 1'b0;
        step();
        arm = 1'b1; trig_en = 1'b1; trig_pc = 32'h100; rd_ready = 1'b0;
        step();
        event_in(1'b1, 4'd5, 32'hAA, 32'hF8);  step();
        event_in(1'b1, 4'd6, 32'hBB, 32'hFC);  step();
        check("t2 waiting", st[0], 2'b01);
        check("t2 nothing yet", lvl[0], 5'd0);
        event_in(1'b1, 4'd7, 32'hCC, 32'h100); step();
        check("t2 triggered", st[0], 2'b10);
        check("t2 trig entry", rpc[0], 32'h100);
        event_in(1'b1, 4'd8, 32'hDD, 32'h104); step();
        check("t2 two entries", lvl[0], 5'd2);
        event_in(1'b0, 4'd0, 32'd0, 32'd0);
        rd_ready = 1'b1;
        step();
        check("t2 second pc", rpc[0], 32'h104);
        step();

        // T3: overflow with no consumer; halting instance stops after the 17th event
        arm = 1'b0; trig_en = 1'b0;
        step();
        arm = 1'b1; rd_ready = 1'b0;
        step();
        for (int k = 1; k <= 18; k++) begin
            event_in(1'b1, 4'(k), 32'h3000 + 32'(k), 32'h400 + 32'(4 * k));
            step();
        end
        check("t3 level", lvl[0], 5'd16);
        check("t3 overflow", ovf[0], 1'b1);
        check("t3 drops", dcnt[0], 8'd2);
        check("t5 halted", st[1], 2'b11);
        check("t5 halt drops", dcnt[1], 8'd1);

        // T4: full FIFO, push and pop on the same edge
        event_in(1'b1, 4'hE, 32'hABCD, 32'h500);
        rd_ready = 1'b1;
        step();
        check("t4 level kept", lvl[0], 5'd16);
        check("t4 drops kept", dcnt[0], 8'd2);
        check("t5 halt ignores", lvl[1], 5'd15);

        // T5: disarm and drain everything
        arm = 1'b0;
        event_in(1'b0, 4'd0, 32'd0, 32'd0);
        step();
        check("t5 idle", st[1], 2'b00);
        for (int k = 0; k < 18; k++) step();
        check("t4 last out", rdat[0], 32'hABCD);
        check("t5 last out", rdat[1], 32'h3010);
        check("t5 empty", lvl[1], 5'd0);

        // T6: reset with five entries queued
        arm = 1'b1; rd_ready = 1'b0;
        step();
        check("t6 rearm clears", ovf[0], 1'b0);
        for (int k = 1; k <= 5; k++) begin
            event_in(1'b1, 4'(k), 32'h6000 + 32'(k), 32'h600 + 32'(4 * k));
            step();
        end
        check("t6 level", lvl[0], 5'd5);
        reset = 1'b1;
        step();
        check("t6 flushed", lvl[0], 5'd0);
        check("t6 no valid", rdv[0], 1'b0);
        check("t6 idle", st[0], 2'b00);
        check("t6 overflow", ovf[0], 1'b0);
        reset = 1'b0;

        // drop counter saturation
        arm = 1'b1; trig_en = 1'b0; rd_ready = 1'b0;
        for (int k = 0; k < 300; k++) begin
            event_in(1'b1, 4'(k), $urandom, 32'h700);
            step();
        end
        check("drop saturate", dcnt[0], 8'd255);
        arm = 1'b0;
        step();

        // randomized traffic
        for (int n = 0; n < 4000; n++) begin
            reset = ($urandom_range(0, 499) == 0);
            arm   = ($urandom_range(0, 59) != 0);
            if (n % 200 == 0) begin
                trig_en = 1'($urandom_range(0, 1));
                trig_pc = 32'h100 + 32'(4 * $urandom_range(0, 3));
            end
            event_in(($urandom_range(0, 9) < 7), 4'($urandom), $urandom,
                     32'h100 + 32'(4 * $urandom_range(0, 7)));
            if (((n / 250) % 2) == 1) rd_ready = ($urandom_range(0, 9) < 2);
            else                      rd_ready = ($urandom_range(0, 9) < 8);
            step();
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule
